instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the main control decoder: owns the PC, issues in-order reads to instruction memory,

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: widths, NOP, decoder opcodes and fetch FSM state encodings.
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: registered synchronous FIFO with push/pop/flush and an occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push && (cnt_q != (AW+1)'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);

  // Flush wins over a same-cycle push; a same-cycle pop has already delivered its word.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem reads and hands {instr, pc} to decode.
// Build option FETCH_PERF_CNT_EN adds the perf_fetched / perf_stall counter outputs.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  import instr_fetch_unit_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [CW-1:0]      outst, outst_d;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        credit_used;
  logic               tag_empty, fifo_empty;
  logic               accept, rsp_take, push, pop;
  logic [XLEN-1:0]    rsp_pc;
  logic [31+XLEN:0]   fifo_rdata;

  assign pop         = !fifo_empty && if_ready;
  assign credit_used = {1'b0, outst} + {1'b0, fifo_count} - (CW+1)'(pop);

  assign imem_req_valid = (state_q == S_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (including stragglers after reset) is dropped.
  assign rsp_take = imem_rsp_valid && !tag_empty;
  assign push     = rsp_take && (state_q == S_RUN);
  assign outst_d  = outst + CW'(accept) - CW'(rsp_take);

  // The tag queue remembers each accepted address; its occupancy is the outstanding count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (rsp_take),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (rsp_pc),
    .empty (tag_empty),
    .count (outst)
  );

  fetch_fifo #(.WIDTH(32 + XLEN), .DEPTH(FIFO_DEPTH)) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({rsp_pc, imem_rsp_data}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign if_valid = !fifo_empty;
  assign if_instr = fifo_rdata[31:0];
  assign if_pc    = fifo_rdata[32 +: XLEN];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (redirect_valid && (outst_d != '0)) state_d = S_DRAIN;
      S_DRAIN: if (outst_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (accept)     pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else if (state_q != S_BOOT) begin
      if (pop)                               perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((state_q == S_RUN) && fifo_empty)  perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed tests push expected decode PCs,
// a monitor pops and compares every decode transfer.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int          assertCount = 0;
  int          failCount   = 0;
  int          consumed    = 0;
  int          startCnt;
  int          pops;
  bit          rspEnable   = 1'b1;
  bit          found;
  logic [31:0] expPc;
  logic [31:0] expPcQ[$];
  logic [31:0] pendQ[$];
  logic [31:0] acceptLog[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  function automatic logic [31:0] instrFor(input logic [31:0] a);
    return {a[24:0], 7'b0010011} ^ 32'h5A00_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [31:0] basePc, input int n);
    for (int i = 0; i < n; i++) expPcQ.push_back(basePc + 32'(4 * i));
  endtask

  // Instruction memory: one-cycle latency, in order, responses held back while rspEnable=0.
  always @(posedge clk) begin
    if (!rst_n) pendQ.delete();
    else if (imem_req_valid && imem_req_ready) begin
      pendQ.push_back(imem_req_addr);
      acceptLog.push_back(imem_req_addr);
    end
    #1;
    if (rst_n && rspEnable && pendQ.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instrFor(pendQ.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Decode-side monitor: every transfer must match the head of the expected queue.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && if_valid && if_ready) begin
      consumed++;
      if (expPcQ.size() == 0) begin
        checkOutput("sb_xfer_expected", 64'(expPcQ.size() != 0), 64'd1);
      end else begin
        expPc = expPcQ.pop_front();
        checkOutput("sb_pc", 64'(if_pc), 64'(expPc));
        checkOutput("sb_instr", 64'(if_instr), 64'(instrFor(expPc)));
      end
    end
  end

  task automatic applyStimulus(input bit useRedirect, input logic [31:0] bootPc);
    @(negedge clk);
    rst_n = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; rspEnable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expPcQ.delete();
    acceptLog.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
    checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
    rst_n = 1'b1;
    if (useRedirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = bootPc;
    end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic waitConsumed(input int target, input string name);
    for (int i = 0; i < 200 && consumed < target; i++) @(negedge clk);
    checkOutput(name, 64'(consumed >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Test 1: streaming fetch from reset
    applyStimulus(1'b0, 32'h0);
    if_ready = 1'b1;
    startCnt = consumed;
    pushExpected(32'h0, 16);
    checkOutput("t1_req_valid", 64'(imem_req_valid), 64'd1);
    checkOutput("t1_req_addr0", 64'(imem_req_addr), 64'h0);
    @(negedge clk); #1;
    checkOutput("t1_if_valid_lat", 64'(if_valid), 64'd0);
    checkOutput("t1_req_addr1", 64'(imem_req_addr), 64'h4);
    @(negedge clk); #1;
    checkOutput("t1_if_valid", 64'(if_valid), 64'd1);
    checkOutput("t1_if_pc0", 64'(if_pc), 64'h0);
    waitConsumed(startCnt + 6, "t1_consume_timeout");
    checkOutput("t1_accept2", 64'(acceptLog.size() > 2 ? acceptLog[2] : 32'hDEAD_BEEF), 64'h8);

    // Test 2: decode backpressure fills the buffer and stops requests
    applyStimulus(1'b0, 32'h0);
    startCnt = consumed;
    pushExpected(32'h0, 16);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (if_valid) found = 1'b1;
    end
    checkOutput("t2_valid_seen", 64'(found), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checkOutput("t2_req_blocked", 64'(imem_req_valid), 64'd0);
      checkOutput("t2_hold_pc", 64'(if_pc), 64'h0);
      checkOutput("t2_hold_instr", 64'(if_instr), 64'(instrFor(32'h0)));
    end
    checkOutput("t2_accepts_stalled", 64'(acceptLog.size()), 64'd2);
    @(negedge clk);
    if_ready = 1'b1;
    waitConsumed(startCnt + 3, "t2_consume_timeout");

    // Test 3: redirect with two outstanding fetches drains both
    applyStimulus(1'b0, 32'h0);
    rspEnable = 1'b0;
    if_ready  = 1'b1;
    startCnt  = consumed;
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("t3_credit_full", 64'(imem_req_valid), 64'd0);
    pushExpected(32'h100, 8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    rspEnable      = 1'b1;
    #1;
    checkOutput("t3_drain_no_req", 64'(imem_req_valid), 64'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_req_valid) begin
        found = 1'b1;
        checkOutput("t3_first_addr", 64'(imem_req_addr), 64'h100);
      end
    end
    checkOutput("t3_drain_ends", 64'(found), 64'd1);
    waitConsumed(startCnt + 3, "t3_consume_timeout");

    // Test 4: redirect coinciding with the transfer of pc 0x4
    applyStimulus(1'b0, 32'h0);
    if_ready = 1'b1;
    startCnt = consumed;
    pushExpected(32'h0, 2);
    pushExpected(32'h200, 8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (if_valid && if_pc == 32'h4) begin
        found = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
      end
    end
    checkOutput("t4_pc4_seen", 64'(found), 64'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    waitConsumed(startCnt + 4, "t4_consume_timeout");

    // Test 5: unaligned redirect target, then PC wrap at the top of memory
    applyStimulus(1'b1, 32'h103);
    if_ready = 1'b1;
    startCnt = consumed;
    pushExpected(32'h100, 8);
    checkOutput("t5_aligned_addr", 64'(imem_req_addr), 64'h100);
    waitConsumed(startCnt + 3, "t5a_consume_timeout");

    applyStimulus(1'b1, 32'hFFFF_FFFD);
    if_ready = 1'b1;
    startCnt = consumed;
    expPcQ.push_back(32'hFFFF_FFFC);
    pushExpected(32'h0, 8);
    checkOutput("t5_top_addr", 64'(imem_req_addr), 64'hFFFF_FFFC);
    waitConsumed(startCnt + 3, "t5b_consume_timeout");
    checkOutput("t5_wrap_accept", 64'(acceptLog.size() > 1 ? acceptLog[1] : 32'hDEAD_BEEF), 64'h0);

`ifdef FETCH_PERF_CNT_EN
    // Test 6: ten consumes with three empty run cycles
    applyStimulus(1'b0, 32'h0);
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    startCnt       = consumed;
    pushExpected(32'h0, 20);
    @(negedge clk);
    imem_req_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 100 && pops < 10; i++) begin
      @(negedge clk); #1;
      if (if_valid) pops++;
    end
    @(negedge clk);
    if_ready       = 1'b0;
    imem_req_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_consumed", 64'(consumed - startCnt), 64'd10);
    checkOutput("t6_perf_fetched", 64'(perf_fetched), 64'd10);
    checkOutput("t6_perf_stall", 64'(perf_stall), 64'd3);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
